hba_servo: RTL and testbench

HBA bus slave peripheral that generates two hobby-servo pulse trains (20 ms frame, 1.000–2.020 ms pulse) from 8-bit position registers. It occupies slot 6 of the HBRC peripheral system, beside the motor, sonar and quadrature slaves, and is reached through the serial_fpga master. It raises a frame-done interrupt so host software can update positions once per frame without glitches.

---
 rtl/hba_servo_pkg.sv | 28 ++
 rtl/hba_servo_channel.sv | 46 ++++
 rtl/hba_servo.sv | 156 +++++++++++++++
 tb/tb_hba_servo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hba_servo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hba_servo_pkg : register map, CTRL bits, timing and bus FSM codes   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package hba_servo_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_POS0   = 2'd1;
  localparam logic [1:0] REG_POS1   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int         CTRL_EN0    = 0;
  localparam int         CTRL_EN1    = 1;
  localparam int         CTRL_IRQ_EN = 7;
  localparam logic [7:0] CTRL_MASK   = 8'h83;

  localparam int TICK_HZ     = 250_000;
  localparam int FRAME_TICKS = 5000;
  localparam int MIN_TICKS   = 250;
  localparam int FRAME_W     = 13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hba_servo_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | servo_channel : per-frame shadow of pos/enable plus pulse compare   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module servo_channel
  import hba_servo_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_start_i,
  input  logic [FRAME_W-1:0] frame_cnt_d_i,
  input  logic               en_i,
  input  logic [7:0]         pos_i,
  output logic               pwm_o
);

  logic       en_q,  en_d;
  logic [7:0] pos_q, pos_d;
  logic       pwm_q, pwm_d;
  logic [8:0] thresh;

  // Compare against next-state values so the output rises on the wrap edge.
  always_comb begin
    en_d   = frame_start_i ? en_i  : en_q;
    pos_d  = frame_start_i ? pos_i : pos_q;
    thresh = 9'(MIN_TICKS) + {1'b0, pos_d};
    pwm_d  = en_d && (frame_cnt_d_i < {{(FRAME_W-9){1'b0}}, thresh});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q  <= 1'b0;
      pos_q <= 8'h80;
      pwm_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      pos_q <= pos_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/hba_servo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hba_servo : HBA slave driving two hobby-servo pulse trains          |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module hba_servo
  import hba_servo_pkg::*;
#(
  parameter int CLK_FREQUENCY     = 60_000_000,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 6
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [1:0]            servo_pwm
);

  localparam int PRE_DIV = CLK_FREQUENCY / TICK_HZ;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  tick, frame_wrap, frame_start;
  logic [1:0]            state_q, state_d;
  logic                  slot_hit, capture, ack, wr_en;
  logic [1:0]            idx_q;
  logic                  rnw_q;
  logic [7:0]            wdata_q;
  logic [DBUS_WIDTH-1:0] rdata_q;
  logic [7:0]            rd_mux;
  logic [7:0]            ctrl_q;
  logic [1:0][7:0]       pos_q;
  logic                  flag_q, flag_d;
  logic                  unused_abus;

  assign unused_abus = ^hba_abus[ADDR_WIDTH-PERIPH_ADDR_WIDTH-1:2];

  always_comb begin
    tick        = (pre_q == PRE_W'(PRE_DIV - 1));
    pre_d       = tick ? '0 : pre_q + PRE_W'(1);
    frame_wrap  = (frame_q == FRAME_W'(FRAME_TICKS - 1));
    frame_start = tick && frame_wrap;
    frame_d     = frame_q;
    if (tick) frame_d = frame_wrap ? '0 : frame_q + FRAME_W'(1);
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      pre_q   <= '0;
      frame_q <= '0;
    end else begin
      pre_q   <= pre_d;
      frame_q <= frame_d;
    end
  end

  // Bus FSM: WAIT absorbs a long select so one transfer gets one ack.
  assign slot_hit = hba_select &&
                    (hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

  always_ff @(posedge hba_clk) begin
    if (hba_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (slot_hit)    state_d = ST_ACK;
      ST_ACK:                   state_d = ST_WAIT;
      ST_WAIT: if (!hba_select) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture        = (state_q == ST_IDLE) && slot_hit;
    ack            = (state_q == ST_ACK);
    wr_en          = ack && !rnw_q;
    hba_dbus_slave = (ack && rnw_q) ? rdata_q : '0;
  end

  assign hba_xferack_slave = ack;

  always_comb begin
    rd_mux = '0;
    case (hba_abus[1:0])
      REG_CTRL:   rd_mux = ctrl_q;
      REG_POS0:   rd_mux = pos_q[0];
      REG_POS1:   rd_mux = pos_q[1];
      REG_STATUS: rd_mux = {7'b0, flag_q};
      default:    rd_mux = '0;
    endcase
  end

  // A frame start outranks a same-cycle STATUS write.
  always_comb begin
    flag_d = flag_q;
    if (wr_en && (idx_q == REG_STATUS)) flag_d = 1'b0;
    if (frame_start)                    flag_d = 1'b1;
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      idx_q   <= '0;
      rnw_q   <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      ctrl_q  <= '0;
      pos_q   <= {8'h80, 8'h80};
      flag_q  <= 1'b0;
    end else begin
      if (capture) begin
        idx_q   <= hba_abus[1:0];
        rnw_q   <= hba_rnw;
        wdata_q <= hba_dbus[7:0];
        rdata_q <= DBUS_WIDTH'(rd_mux);
      end
      if (wr_en) begin
        case (idx_q)
          REG_CTRL: ctrl_q   <= wdata_q & CTRL_MASK;
          REG_POS0: pos_q[0] <= wdata_q;
          REG_POS1: pos_q[1] <= wdata_q;
          default:  ;
        endcase
      end
      flag_q <= flag_d;
    end
  end

  assign slave_interrupt = flag_q & ctrl_q[CTRL_IRQ_EN];

  for (genvar n = 0; n < 2; n++) begin : g_chan
    servo_channel u_chan (
      .clk_i         (hba_clk),
      .rst_i         (hba_reset),
      .frame_start_i (frame_start),
      .frame_cnt_d_i (frame_d),
      .en_i          (ctrl_q[n]),
      .pos_i         (pos_q[n]),
      .pwm_o         (servo_pwm[n])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_hba_servo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hba_servo : randomized bench against a cycle-arithmetic model    |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_hba_servo;

  localparam int CLKF      = 500_000;
  localparam int DIV       = CLKF / 250_000;
  localparam int FRAME_CYC = DIV * 5000;

  logic        hba_clk;
  logic        hba_reset;
  logic        hba_rnw;
  logic        hba_select;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;
  logic [7:0]  hba_dbus_slave;
  logic        hba_xferack_slave;
  logic        slave_interrupt;
  logic [1:0]  servo_pwm;

  hba_servo #(
    .CLK_FREQUENCY (CLKF),
    .PERIPH_ADDR   (6)
  ) dut (
    .hba_clk           (hba_clk),
    .hba_reset         (hba_reset),
    .hba_rnw           (hba_rnw),
    .hba_select        (hba_select),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_slave    (hba_dbus_slave),
    .hba_xferack_slave (hba_xferack_slave),
    .slave_interrupt   (slave_interrupt),
    .servo_pwm         (servo_pwm)
  );

  initial hba_clk = 1'b0;
  always #5 hba_clk = ~hba_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: k = clean edges since reset; frame timing follows from k alone.
  int         k;
  logic [7:0] m_ctrl;
  logic [7:0] m_pos [2];
  logic       m_flag;
  logic [1:0] sh_en;
  logic [7:0] sh_pos [2];
  bit         pend;
  logic [1:0] pend_idx;
  logic [7:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [1:0] i);
    case (i)
      2'd0:    return m_ctrl;
      2'd1:    return m_pos[0];
      2'd2:    return m_pos[1];
      default: return {7'b0, m_flag};
    endcase
  endfunction

  task automatic step();
    bit         fs;
    int         tk;
    logic [1:0] e;
    @(posedge hba_clk);
    if (hba_reset) begin
      k = 0; m_ctrl = 8'h00; m_pos[0] = 8'h80; m_pos[1] = 8'h80; m_flag = 1'b0;
      sh_en = 2'b00; sh_pos[0] = 8'h80; sh_pos[1] = 8'h80; pend = 1'b0;
    end else begin
      k++;
      fs = ((k % FRAME_CYC) == 0);
      if (fs) begin
        sh_en = m_ctrl[1:0]; sh_pos[0] = m_pos[0]; sh_pos[1] = m_pos[1];
      end
      if (pend) begin
        case (pend_idx)
          2'd0:    m_ctrl   = pend_data & 8'h83;
          2'd1:    m_pos[0] = pend_data;
          2'd2:    m_pos[1] = pend_data;
          default: m_flag   = 1'b0;
        endcase
        pend = 1'b0;
      end
      if (fs) m_flag = 1'b1;
    end
    @(negedge hba_clk);
    tk = (k % FRAME_CYC) / DIV;
    for (int n = 0; n < 2; n++) e[n] = sh_en[n] && (tk < 250 + int'(sh_pos[n]));
    chk("pwm", 32'(servo_pwm), 32'(e));
    chk("irq", 32'(slave_interrupt), 32'(m_flag & m_ctrl[7]));
  endtask

  task automatic run_until_phase(input int p);
    bit hit_p = 1'b0;
    for (int i = 0; i < FRAME_CYC + 2 && !hit_p; i++) begin
      step();
      hit_p = ((k % FRAME_CYC) == p);
    end
    chk("run_bound", 32'(hit_p), 32'd1);
  endtask

  task automatic bus(input logic [11:0] addr, input logic rnw, input logic [7:0] wd,
                     input int hold, output logic [7:0] rd);
    bit         hit    = (addr[11:8] == 4'h6);
    logic [7:0] exp_rd = mread(addr[1:0]);
    rd = 8'h00;
    hba_select = 1'b1; hba_abus = addr; hba_rnw = rnw; hba_dbus = wd;
    for (int i = 0; i < hold; i++) begin
      if (i == 1 && hit && !rnw) begin
        pend = 1'b1; pend_idx = addr[1:0]; pend_data = wd;
      end
      step();
      if (i == 0) rd = hba_dbus_slave;
      chk("ack", 32'(hba_xferack_slave), 32'(hit && i == 0));
      chk("rdata", 32'(hba_dbus_slave), (hit && i == 0 && rnw) ? 32'(exp_rd) : 32'd0);
    end
    hba_select = 1'b0; hba_rnw = 1'b1;
    step();
    chk("ack_idle", 32'(hba_xferack_slave), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] idx;
    logic [5:0] hi;
    int         w0, w1;

    hba_reset = 1'b1; hba_select = 1'b0; hba_rnw = 1'b1; hba_abus = '0; hba_dbus = '0;
    @(negedge hba_clk);
    for (int i = 0; i < 3; i++) step();
    chk("rst_ack", 32'(hba_xferack_slave), 32'd0);
    chk("rst_dbus", 32'(hba_dbus_slave), 32'd0);
    chk("rst_pwm", 32'(servo_pwm), 32'd0);
    hba_reset = 1'b0;
    step();

    bus(12'h601, 1'b1, 8'h00, 3, rd);
    chk("pos0_reset", 32'(rd), 32'h80);

    bus(12'h601, 1'b0, 8'h00, 2, rd);
    bus(12'h600, 1'b0, 8'h03, 2, rd);
    run_until_phase(0);
    chk("pwm_rise", 32'(servo_pwm), 32'h3);

    // Mid-pulse POS1 change must not touch the pulse already in flight.
    run_until_phase(100);
    bus(12'h602, 1'b0, 8'hFF, 2, rd);
    run_until_phase(0);
    w0 = 0; w1 = 0;
    for (int i = 0; i < 1200; i++) begin
      if (servo_pwm[0]) w0++;
      if (servo_pwm[1]) w1++;
      step();
    end
    chk("ch0_width", 32'(w0), 32'(250 * DIV));
    chk("ch1_width", 32'(w1), 32'(505 * DIV));

    bus(12'h603, 1'b0, 8'($urandom), 2, rd);
    bus(12'h600, 1'b0, 8'h83, 2, rd);
    chk("irq_before", 32'(slave_interrupt), 32'd0);
    run_until_phase(0);
    chk("irq_frame", 32'(slave_interrupt), 32'd1);
    bus(12'h603, 1'b0, 8'($urandom), 2, rd);
    chk("irq_clear", 32'(slave_interrupt), 32'd0);

    // STATUS write committing on the frame-start edge.
    run_until_phase(FRAME_CYC - 2);
    bus(12'h603, 1'b0, 8'($urandom), 2, rd);
    chk("irq_collide", 32'(slave_interrupt), 32'd1);

    for (int j = 0; j < 8; j++) begin
      idx = 2'($urandom);
      hi  = 6'($urandom);
      bus({4'h6, hi, idx}, 1'($urandom), 8'($urandom), int'($urandom_range(4, 2)), rd);
      for (int c = 0; c < int'($urandom_range(300, 0)); c++) step();
    end
    run_until_phase(1200);

    bus(12'h501, 1'b1, 8'h00, 5, rd);
    bus(12'h601, 1'b1, 8'h00, 5, rd);

    bus(12'h600, 1'b0, 8'h03, 2, rd);
    run_until_phase(0);
    run_until_phase(100);
    chk("pwm_mid", 32'(servo_pwm), 32'h3);
    hba_reset = 1'b1;
    step();
    chk("pwm_after_rst", 32'(servo_pwm), 32'd0);
    hba_reset = 1'b0;
    step();

    bus(12'h600, 1'b0, 8'h03, 2, rd);
    hba_select = 1'b1; hba_abus = 12'h600; hba_rnw = 1'b0; hba_dbus = 8'h83;
    step();
    chk("ack_pre_rst", 32'(hba_xferack_slave), 32'd1);
    hba_reset = 1'b1; hba_select = 1'b0; hba_rnw = 1'b1;
    step();
    chk("ack_rst", 32'(hba_xferack_slave), 32'd0);
    chk("dbus_rst", 32'(hba_dbus_slave), 32'd0);
    hba_reset = 1'b0;
    step();
    bus(12'h600, 1'b1, 8'h00, 2, rd);
    chk("ctrl_after_rst", 32'(rd), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
